// File: rtl/wide_adder_seq_if.sv
// Operand request and result handshake bundle for wide_adder_seq.
// The master side is the operand source and the result consumer.
interface wide_adder_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/wide_adder_seq.sv
// Multi-cycle WORDS x 16-bit adder/subtractor chaining a
// 16-bit Kogge-Stone prefix adder through a carry register.
module prefix_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] p0;
  logic [15:0] gv;
  logic [15:0] pv;
  logic [15:0] gn;
  logic [15:0] pn;
  logic [16:0] c;

  // c_in is folded into bit 0 generate so G[i:0] is carry i+1
  always_comb begin
    p0 = a ^ b;
    gv = a & b;
    gv[0] = gv[0] | (p0[0] & c_in);
    pv = p0;
    gn = '0;
    pn = '0;
    for (int lv = 0; lv < 4; lv++) begin
      gn = gv;
      pn = pv;
      for (int i = (1 << lv); i < 16; i++) begin
        gn[i] = gv[i] | (pv[i] & gv[i - (1 << lv)]);
        pn[i] = pv[i] & pv[i - (1 << lv)];
      end
      gv = gn;
      pv = pn;
    end
    c = {gv, c_in};
    sum = p0 ^ c[15:0];
    c_out = c[16];
  end
endmodule

module wide_adder_seq #(
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  wide_adder_seq_if.slave  io
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   a_q;
  logic [W-1:0]   bm_q;
  logic [W-1:0]   sum_q;
  logic           cy_q;
  logic           ov_q;
  logic [IW-1:0]  idx_q;
  logic           accept;
  logic           last;
  logic [15:0]    ca;
  logic [15:0]    cb;
  logic [15:0]    ps;
  logic           pco;

  assign io.in_ready = (state_q == IDLE) |
                       ((state_q == DONE) & io.out_ready);
  assign accept      = io.in_valid & io.in_ready;
  assign last        = (idx_q == IW'(WORDS - 1));

  assign ca = a_q[16*idx_q +: 16];
  assign cb = bm_q[16*idx_q +: 16];

  prefix_adder_16 u_pa (
    .a     (ca),
    .b     (cb),
    .c_in  (cy_q),
    .sum   (ps),
    .c_out (pco)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (last) state_d = DONE;
      DONE: if (io.out_ready)
              state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      bm_q  <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
      ov_q  <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      a_q   <= io.a;
      bm_q  <= io.sub ? ~io.b : io.b;
      cy_q  <= io.sub | io.c_in;
      idx_q <= '0;
    end else if (state_q == BUSY) begin
      sum_q[16*idx_q +: 16] <= ps;
      cy_q  <= pco;
      idx_q <= last ? '0 : idx_q + 1'b1;
      if (last)
        ov_q <= a_q[W-1] ^ bm_q[W-1] ^ ps[15] ^ pco;
    end
  end

  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_q;
  assign io.c_out     = cy_q;
  assign io.overflow  = ov_q;
endmodule

// File: tb/tb_wide_adder_seq.sv
// Directed bench for wide_adder_seq, WORDS=4.
// Hand-computed vectors; all checks go through chk.
module tb_wide_adder_seq;
  localparam int WORDS = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  wide_adder_seq_if #(.WORDS(WORDS)) io ();

  wide_adder_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!io.out_valid && n < 20);
  endtask

  task automatic run_op(input string tag,
                        input logic [63:0] a,
                        input logic [63:0] b,
                        input logic cin,
                        input logic sub,
                        input logic [63:0] es,
                        input logic ec,
                        input logic eo);
    int n;
    chk({tag, "_rdy"}, 64'(io.in_ready), 64'd1);
    io.a = a;
    io.b = b;
    io.c_in = cin;
    io.sub = sub;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    io.a = {$urandom, $urandom};
    io.b = {$urandom, $urandom};
    io.c_in = ~cin;
    io.sub = ~sub;
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'(WORDS));
    chk({tag, "_sum"}, io.sum, es);
    chk({tag, "_c"}, 64'(io.c_out), 64'(ec));
    chk({tag, "_ov"}, 64'(io.overflow), 64'(eo));
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk({tag, "_rel"}, 64'(io.out_valid), 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    io.in_valid = 1'b1;
    io.a = {$urandom, $urandom};
    io.b = {$urandom, $urandom};
    io.c_in = 1'b1;
    io.sub = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ov_v", 64'(io.out_valid), 64'd0);
    chk("rst_sum", io.sum, 64'd0);
    chk("rst_c", 64'(io.c_out), 64'd0);
    chk("rst_ovf", 64'(io.overflow), 64'd0);
    chk("rst_rdy", 64'(io.in_ready), 64'd1);
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_v", 64'(io.out_valid), 64'd0);

    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
           1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("sub57", 64'd5, 64'd7, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub75", 64'd7, 64'd5, 1'b1, 1'b1,
           64'd2, 1'b1, 1'b0);
    run_op("ovadd", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
           1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("ovsub", 64'h8000_0000_0000_0000, 64'h1,
           1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("mix", 64'h1234_5678_9ABC_DEF0,
           64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
           64'h2222_2222_2222_2212, 1'b0, 1'b0);

    // backpressure with a second request waiting
    io.a = 64'd1;
    io.b = 64'd2;
    io.c_in = 1'b0;
    io.sub = 1'b0;
    io.in_valid = 1'b1;
    tick();
    wait_done(n);
    chk("bp_lat", 64'(n), 64'(WORDS));
    for (int i = 0; i < 10; i++) begin
      io.a = {$urandom, $urandom};
      io.b = {$urandom, $urandom};
      tick();
      chk("bp_sum", io.sum, 64'd3);
      chk("bp_c", 64'(io.c_out), 64'd0);
      chk("bp_ov", 64'(io.overflow), 64'd0);
      chk("bp_rdy", 64'(io.in_ready), 64'd0);
      chk("bp_vld", 64'(io.out_valid), 64'd1);
    end
    io.a = 64'd10;
    io.b = 64'd20;
    io.out_ready = 1'b1;
    #1;
    chk("b2b_rdy", 64'(io.in_ready), 64'd1);
    tick();
    io.out_ready = 1'b0;
    io.in_valid = 1'b0;
    chk("b2b_busy", 64'(io.out_valid), 64'd0);
    wait_done(n);
    chk("b2b_lat", 64'(n), 64'(WORDS));
    chk("b2b_sum", io.sum, 64'd30);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;

    // reset in the middle of an operation
    io.a = 64'h100;
    io.b = 64'h200;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_vld", 64'(io.out_valid), 64'd0);
    chk("mid_rdy", 64'(io.in_ready), 64'd1);
    chk("mid_sum", io.sum, 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (io.out_valid) seen++;
    end
    chk("mid_none", 64'(seen), 64'd0);
    run_op("after", 64'h1234_5678_9ABC_DEF0,
           64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
           64'h2222_2222_2222_2212, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wide_adder_seq.md
# wide_adder_seq

Multi-cycle wide-operand adder/subtractor built around one `prefix_adder_16` instance. It accepts a WORDS×16-bit operand pair over a valid/ready handshake and feeds the 16-bit prefix adder one chunk per cycle, LSB chunk first. It chains the carry through a register between chunks and presents the full-width result, carry-out and signed overflow over a second valid/ready handshake. It sits between the operand source (register file / datapath) and the result consumer, and is the only producer of operands for the prefix adder.

## Interface
- `WORDS`, default 4: number of 16-bit chunks; operand width W = 16*WORDS; legal range 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept an operand request this cycle.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `c_in`  in  1  carry-in for addition; ignored when `sub`=1.
- `sub`  in  1  0: A+B+c_in; 1: A−B, computed as A+~B+1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  W  result.
- `c_out`  out  1  carry out of bit W−1; for subtraction 1 = no borrow (A ≥ B unsigned).
- `overflow`  out  1  two's-complement signed overflow of the full-width operation.

## Operation
- States: IDLE, BUSY, DONE. Internal chunk counter `idx` is ceil(log2(WORDS)) bits wide.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). It is combinational.
- Accept occurs when `in_valid & in_ready`. On accept:
  - Latch A into the A register.
  - Latch B into the B register, bitwise inverted if `sub`.
  - Set the carry register to (`sub` ? 1 : `c_in`).
  - Latch the op flag.
  - Set `idx`=0 and move to BUSY.
- BUSY, every cycle:
  - The prefix adder receives chunk `idx` of the A register, chunk `idx` of the B register, and the carry register as `c_in`.
  - Its 16-bit sum is written to chunk `idx` of the sum register, and the carry register takes its `c_out`.
  - `idx` increments.
  - When `idx`==WORDS−1, the chunk is written, state moves to DONE, and `out_valid` is set.
- DONE:
  - `sum` and `c_out` (the final carry register) are held stable while `out_ready`=0.
  - `overflow` = A[W−1] ^ Bm[W−1] ^ sum[W−1] ^ c_out, where Bm is the stored (possibly inverted) B.
  - `out_valid & out_ready` releases the result. State goes to IDLE, unless an accept happens in the same cycle, in which case it goes to BUSY (back-to-back, no bubble).
- `in_valid` while BUSY, or while in DONE with `out_ready`=0, is not accepted; the upstream must hold its request.
- `a`, `b`, `c_in`, `sub` are sampled only on the accept edge. Later changes have no effect on an in-flight operation.
- Chunk arithmetic is modulo 2^16. The carry between chunks is exactly the `c_out` of the previous chunk. The result equals (A + Bm + cin0) mod 2^W, with carry bit W.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `out_valid`=0, `sum`=0, `c_out`=0, `overflow`=0, `idx`=0, carry register =0.
  - `in_ready`=1 while in reset.
- Latency: an accept on edge T gives `out_valid`=1 after edge T+WORDS (4 cycles for the default).
- Throughput with `out_ready` tied high: one result every WORDS cycles.
- Reset asserted mid-operation (BUSY or DONE) discards the operation. No `out_valid` is produced for it after reset release.
- Outputs are registered. The only combinational output is `in_ready`, which depends only on state and `out_ready`.

## Test plan
- Reset: assert `rst_n`=0 with random inputs, then release. Required: `out_valid`=0, `sum`=0, `c_out`=0, `overflow`=0, `in_ready`=1, with no spurious handshake.
- Full carry ripple across chunks: WORDS=4, add, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, `c_in`=0. Required: `sum`=0, `c_out`=1, `overflow`=0, and `out_valid` rises exactly 4 cycles after the accept edge.
- Subtract with borrow: `sub`=1, A=5, B=7, `c_in`=1 (which must be ignored). Required: `sum`=0xFFFF_FFFF_FFFF_FFFE, `c_out`=0, `overflow`=0. Then A=7, B=5 gives `sum`=2, `c_out`=1.
- Signed overflow: add A=0x7FFF_FFFF_FFFF_FFFF, B=1. Required: `sum`=0x8000_0000_0000_0000, `overflow`=1, `c_out`=0. Then sub A=0x8000_0000_0000_0000, B=1 gives `overflow`=1.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 10 cycles in DONE, while toggling `a`/`b` and holding `in_valid`=1. Required: `sum`, `c_out`, `overflow` stable and `in_ready`=0 throughout.
  - Then raise `out_ready` for 1 cycle. Required: the first result is released, the second operation is accepted in the same cycle, and its result appears WORDS cycles later.
- Reset mid-operation: accept an add, drop `rst_n` 2 cycles later for 1 cycle. Required: `out_valid`=0 immediately (asynchronous), state IDLE, no `out_valid` for the aborted request. The next request completes correctly.
